cla_sub: RTL and testbench
==========================

# cla_sub

Registered 16-bit carry-lookahead subtractor computing s = a − b in two's complement, with borrow, signed-overflow and zero flags. It is the integer SUB functional unit in the scoreboard datapath. Operands are captured with a valid strobe, and the result is presented one clock later.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of 4 and at least 4.
- clk  input  1  rising-edge clock. Single clock domain.
- rst_n  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- in_valid  input  1  a and b are valid this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  s and the flags hold a new result.
- s  output  WIDTH  difference a − b, modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned a < b.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  s == 0.

## Operation
- Arithmetic: s = a + ~b + 1. The carry-in of 1 into bit 0 is the two's-complement increment.
- The adder is a carry-lookahead structure:
  - 4-bit CLA blocks, each producing group propagate P and group generate G.
  - A second-level lookahead unit computes the carry into each block.
  - No ripple chain across blocks.
- Flag definitions:
  - borrow_out = NOT carry-out of the MSB.
  - overflow = (a[MSB] != b[MSB]) AND (s[MSB] != a[MSB]).
  - zero = (s == 0).
- Register update on each rising edge of clk:
  - If rst_n == 0: s, borrow_out, overflow, zero and out_valid are all cleared to 0.
  - Else if in_valid == 1: the result registers load the new difference and flags, and out_valid = 1.
  - Else: out_valid = 0, and s and the flags hold their last values.
- The unit accepts a new operand pair every cycle. There is no stall and no back-pressure.
- a == b gives s = 0, zero = 1, borrow_out = 0, overflow = 0.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on the outputs after edge N.
- Throughput is 1 operation per cycle.
- The lookahead path from a/b to the result registers is fully combinational within one cycle.
- Reset values: s = 0, borrow_out = 0, overflow = 0, zero = 0, out_valid = 0.
  - zero is 0 during reset even though s = 0.
- Reset asserted in the same cycle as in_valid: reset wins and the operation is discarded.
- Reset asserted mid-stream: the in-flight result is dropped, and out_valid stays 0 until the first in_valid after rst_n returns to 1.
- Outputs change only on clock edges and are glitch-free to downstream logic.

## Structure
- Shared package `int_alu_pkg` holds:
  - the WIDTH default of 16;
  - the CLA block width constant of 4;
  - a result-flags struct (borrow, overflow, zero).
- One natural sub-module, `cla4`: a 4-bit carry-lookahead block.
  - Inputs: x[3:0], y[3:0], cin.
  - Outputs: sum[3:0], P, G.
- The top level contains:
  - WIDTH/4 generate-instantiated `cla4` blocks;
  - the second-level carry logic;
  - operand inversion;
  - the flag logic and the output registers.

## Test plan
- a=8, b=6, in_valid=1 → next cycle: s=2, borrow_out=0, overflow=0, zero=0, out_valid=1.
- a=6, b=8 → s=0xFFFE, borrow_out=1, overflow=0, zero=0.
- a=0x8000, b=0x0001 → s=0x7FFF, overflow=1, borrow_out=0. Also a=0x7FFF, b=0xFFFF → s=0x8000, overflow=1, borrow_out=1.
- a=b=0x1234 → s=0, zero=1. Also a=0, b=0 → s=0, zero=1, borrow_out=0.
- Back-to-back pairs (100,1), (0,1), (0xFFFF,0xFFFF) on consecutive cycles → results 99, 0xFFFF, 0 on consecutive cycles, with out_valid continuously 1. Then drop in_valid → out_valid=0 and s holds 0.
- Assert rst_n=0 together with in_valid=1 and a=5, b=3 → all outputs 0 the next cycle. Release reset and apply a=5, b=3 → s=2 one cycle later.

Source files
------------

// File: rtl/int_alu_pkg.sv
// Shared integer-ALU definitions: default widths, CLA block size and the
// result-flag bundle produced by the subtract unit.
package int_alu_pkg;

    localparam int SUB_WIDTH = 16;   // default operand/result width
    localparam int CLA_W     = 4;    // bits per first-level lookahead block

    // Carry-in of 1 into bit 0 turns a + ~b into a - b.
    localparam logic SUB_CIN = 1'b1;

    typedef struct packed {
        logic borrow;
        logic overflow;
        logic zero;
    } sub_flags_t;

    localparam sub_flags_t FLAGS_CLR = '{borrow: 1'b0, overflow: 1'b0, zero: 1'b0};

    // Derive the subtract flags from sign bits, the final carry and the
    // all-zero test of the difference.
    function automatic sub_flags_t sub_flags(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic carry_out,
        input logic s_is_zero
    );
        sub_flags_t f;
        f.borrow   = ~carry_out;
        f.overflow = (a_msb != b_msb) && (s_msb != a_msb);
        f.zero     = s_is_zero;
        return f;
    endfunction

endpackage

// File: rtl/cla_sub_if.sv
// Operand/result bundle of the SUB functional unit. The producer side
// (master) drives operands; the unit (slave) drives the registered result.
interface cla_sub_if
    import int_alu_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b,
        input  out_valid, s, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, s, borrow_out, overflow, zero
    );
endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead block. Produces the local sum for a given carry-in
// and the group propagate/generate used by the second-level lookahead.
module cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       P,
    output logic       G
);
    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [3:0] c_s;

    assign p_s = x ^ y;
    assign g_s = x & y;

    // Every internal carry is a flat sum of products of cin, p and g.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign sum = p_s ^ c_s;

    assign P = &p_s;
    assign G = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
endmodule

// File: rtl/cla_sub.sv
// Registered carry-lookahead subtractor: s = a - b (two's complement) with
// borrow, signed-overflow and zero flags, one cycle of latency, one result
// per cycle.
module cla_sub
    import int_alu_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    cla_sub_if.slave   bus
);
    localparam int NB = WIDTH / CLA_W;

    logic [WIDTH-1:0] b_inv_s;
    logic [WIDTH-1:0] sum_s;
    logic [NB-1:0]    grp_p_s;
    logic [NB-1:0]    grp_g_s;
    logic [NB:0]      blk_cin_s;   // [NB] is the carry out of the MSB
    sub_flags_t       flags_s;

    logic [WIDTH-1:0] s_r;
    sub_flags_t       flags_r;
    logic             out_valid_r;

    assign b_inv_s = ~bus.b;

    generate
        for (genvar k = 0; k < NB; k++) begin : g_blk
            cla4 u_cla4 (
                .x   (bus.a[k*CLA_W +: CLA_W]),
                .y   (b_inv_s[k*CLA_W +: CLA_W]),
                .cin (blk_cin_s[k]),
                .sum (sum_s[k*CLA_W +: CLA_W]),
                .P   (grp_p_s[k]),
                .G   (grp_g_s[k])
            );
        end
    endgenerate

    // Second-level lookahead: each block carry-in is an independent OR of
    // products of group G/P terms and the carry-in, never a chained carry.
    always_comb begin
        logic acc_s;
        logic term_s;
        blk_cin_s    = {(NB+1){1'b0}};
        acc_s        = 1'b0;
        term_s       = 1'b0;
        blk_cin_s[0] = SUB_CIN;
        for (int k = 1; k <= NB; k++) begin
            acc_s = 1'b0;
            for (int j = 0; j < k; j++) begin
                term_s = grp_g_s[j];
                for (int m = j + 1; m < k; m++) begin
                    term_s = term_s & grp_p_s[m];
                end
                acc_s = acc_s | term_s;
            end
            term_s = SUB_CIN;
            for (int m = 0; m < k; m++) begin
                term_s = term_s & grp_p_s[m];
            end
            blk_cin_s[k] = acc_s | term_s;
        end
    end

    assign flags_s = sub_flags(bus.a[WIDTH-1], bus.b[WIDTH-1], sum_s[WIDTH-1],
                               blk_cin_s[NB], (sum_s == {WIDTH{1'b0}}));

    // Result registers: reset clears everything (zero included), a valid
    // operand pair loads, otherwise only out_valid drops and data holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r         <= {WIDTH{1'b0}};
            flags_r     <= FLAGS_CLR;
            out_valid_r <= 1'b0;
        end else if (bus.in_valid) begin
            s_r         <= sum_s;
            flags_r     <= flags_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.s          = s_r;
    assign bus.borrow_out = flags_r.borrow;
    assign bus.overflow   = flags_r.overflow;
    assign bus.zero       = flags_r.zero;
    assign bus.out_valid  = out_valid_r;
endmodule

// File: tb/tb_cla_sub.sv
// Self-checking bench for cla_sub: directed vector table, hand-written
// reset/stream sequences, then randomized traffic against a plain
// arithmetic reference model.
module tb_cla_sub;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    cla_sub_if #(.WIDTH(16)) bus ();

    cla_sub #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic v, input logic [15:0] s,
                             input logic bo, input logic ov, input logic z);
        check({nm, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({nm, ".s"},         {16'd0, bus.s},         {16'd0, s});
        check({nm, ".borrow"},    {31'd0, bus.borrow_out}, {31'd0, bo});
        check({nm, ".overflow"},  {31'd0, bus.overflow},  {31'd0, ov});
        check({nm, ".zero"},      {31'd0, bus.zero},      {31'd0, z});
    endtask

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] s, output logic bo,
                                    output logic ov, output logic z);
        int d;
        d  = int'($signed(a)) - int'($signed(b));
        s  = a - b;
        bo = (a < b);
        ov = (d > 32767) || (d < -32768);
        z  = (s == 16'd0);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst_n        = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m_s;
    logic        m_bo, m_ov, m_z, m_v;
    logic [15:0] r_s;
    logic        r_bo, r_ov, r_z;

    initial begin
        vecs[0] = '{16'h0008, 16'h0006, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0006, 16'h0008, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h0F0F, 16'h00F1, 16'h0E1E, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 16'h0000;
        bus.b        = 16'h0000;

        // Reset state.
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        sample();
        check_all("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Directed table, applied back-to-back.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, vecs[i].a, vecs[i].b);
            sample();
            check_all($sformatf("vec%0d", i), 1'b1, vecs[i].s, vecs[i].bo, vecs[i].ov, vecs[i].z);
        end

        // Back-to-back stream then idle: data must hold.
        drive(1'b1, 1'b1, 16'd100, 16'd1);
        sample();
        check_all("b2b0", 1'b1, 16'd99, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd0, 16'd1);
        sample();
        check_all("b2b1", 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        sample();
        check_all("b2b2", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h1111, 16'h0001);
        sample();
        check_all("idle_hold", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 16'h2222, 16'h0003);
        sample();
        check_all("idle_hold2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset together with in_valid: reset wins.
        drive(1'b1, 1'b1, 16'h0006, 16'h0009);
        sample();
        check_all("pre_rst", 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'd5, 16'd3);
        sample();
        check_all("rst_with_valid", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd5, 16'd3);
        sample();
        check_all("post_rst_idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd5, 16'd3);
        sample();
        check_all("post_rst_op", 1'b1, 16'd2, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        m_v  = 1'b1;
        m_s  = 16'd2;
        m_bo = 1'b0;
        m_ov = 1'b0;
        m_z  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        r, v;
            logic [15:0] a, b;
            int          sel;
            r   = ($urandom_range(0, 49) != 0);
            v   = ($urandom_range(0, 3) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                b = a;
            end else if (sel == 1) begin
                a = 16'h8000;
            end else if (sel == 2) begin
                b = 16'h8000;
            end else if (sel == 3) begin
                a = 16'h7FFF;
            end
            drive(r, v, a, b);
            if (!r) begin
                m_v = 1'b0; m_s = 16'h0000; m_bo = 1'b0; m_ov = 1'b0; m_z = 1'b0;
            end else if (v) begin
                ref_sub(a, b, r_s, r_bo, r_ov, r_z);
                m_v = 1'b1; m_s = r_s; m_bo = r_bo; m_ov = r_ov; m_z = r_z;
            end else begin
                m_v = 1'b0;
            end
            sample();
            check_all($sformatf("rnd%0d", i), m_v, m_s, m_bo, m_ov, m_z);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
